fracnet_mul_arbiter: RTL and testbench

Shares one pipelined signed 10×16 multiplier among `NUM_REQ` requesters (conv/BN lanes) in the FracNet datapath. Each cycle it grants at most one pending request, launches it into a 4-stage multiplier, carries the requester tag alongside the operands, and returns the 26-bit product to the issuing requester. A full pipe stalls on response backpressure.

---
 rtl/fracnet_mul_arb_pkg.sv | 26 ++
 rtl/fracnet_mul_arbiter_if.sv | 29 ++
 rtl/fracnet_mul_pipe.sv | 51 +++++
 rtl/fracnet_mul_arbiter.sv | 157 +++++++++++++++
 tb/tb_fracnet_mul_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fracnet_mul_arb_pkg.sv
// Shared widths, multiplier latency, tag sizing and sideband slot type for the multiplier arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fracnet_mul_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int A_W_DEF     = 10;
  localparam int B_W_DEF     = 16;
  localparam int P_W_DEF     = A_W_DEF + B_W_DEF;
  localparam int LAT         = 4;

  // Sideband tag field is sized for up to 16 requesters; only the low bits carry meaning.
  localparam int MUL_TAG_W   = 4;

  // Requester-index width: clog2 of the requester count, never below one bit.
  function automatic int TAG_W(input int num_req);
    return (num_req > 2) ? $clog2(num_req) : 1;
  endfunction

  // One sideband pipe slot travelling alongside the multiplier data.
  typedef struct packed {
    logic                 vld;
    logic [MUL_TAG_W-1:0] tag;
  } mul_slot_t;

endpackage

// File: rtl/fracnet_mul_arbiter_if.sv
// Request/response bundle between the conv/BN lanes and the shared multiplier arbiter.
// Latency: wires only.
// Backpressure: req_ready is the one-hot grant, rsp_ready is per-requester accept.
interface fracnet_mul_arbiter_if #(
  parameter int NUM_REQ = fracnet_mul_arb_pkg::NUM_REQ_DEF,
  parameter int A_W     = fracnet_mul_arb_pkg::A_W_DEF,
  parameter int B_W     = fracnet_mul_arb_pkg::B_W_DEF,
  parameter int P_W     = fracnet_mul_arb_pkg::P_W_DEF
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [NUM_REQ-1:0]     rsp_ready;
  logic [P_W-1:0]         rsp_p;

  // Requester side.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_p
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_p
  );
endinterface

// File: rtl/fracnet_mul_pipe.sv
// Four-stage signed A x B multiplier: input register, multiply, register, output register.
// Latency: 4 enabled cycles from operand capture to product on p.
// Backpressure: ce low freezes every stage; data registers carry no reset.
module fracnet_mul_pipe
  import fracnet_mul_arb_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int B_W = B_W_DEF,
  parameter int P_W = P_W_DEF
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  output logic signed [P_W-1:0] p
);

  logic signed [A_W-1:0] a_q, a_d;
  logic signed [B_W-1:0] b_q, b_d;
  logic signed [P_W-1:0] prod_q, prod_d;
  logic signed [P_W-1:0] mid_q, mid_d;
  logic signed [P_W-1:0] out_q, out_d;

  // Advance all stages together when enabled, otherwise hold.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    prod_d = prod_q;
    mid_d  = mid_q;
    out_d  = out_q;
    if (ce) begin
      a_d    = a;
      b_d    = b;
      prod_d = P_W'(a_q) * P_W'(b_q);
      mid_d  = prod_q;
      out_d  = mid_q;
    end
  end

  // Data registers only; validity is tracked by the sideband pipe in the parent.
  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    prod_q <= prod_d;
    mid_q  <= mid_d;
    out_q  <= out_d;
  end

  assign p = out_q;

endmodule

// File: rtl/fracnet_mul_arbiter.sv
// Shares one pipelined signed multiplier among NUM_REQ requesters; round-robin or fixed-priority grant.
// Latency: request granted in cycle t returns its product in cycle t+LAT, plus one per stall cycle.
// Backpressure: an unaccepted response freezes the whole pipe and blocks grants; FRACNET_MUL_ARB_FIXED_PRIO_EN selects fixed priority.
module fracnet_mul_arbiter
  import fracnet_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int A_W     = A_W_DEF,
  parameter int B_W     = B_W_DEF,
  parameter int P_W     = P_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  fracnet_mul_arbiter_if.slave  bus
);

  localparam int PTR_W = TAG_W(NUM_REQ);

  mul_slot_t             sb_q [LAT];
  mul_slot_t             sb_d [LAT];
  mul_slot_t             out_slot;
  logic                  ce;
  logic                  gnt_found;
  logic                  fire;
  logic [PTR_W-1:0]      gnt_idx;
  logic [PTR_W-1:0]      ptr_q;
  logic [NUM_REQ-1:0]    gnt_oh;
  logic [NUM_REQ-1:0]    rsp_vld_oh;
  logic signed [A_W-1:0] a_sel;
  logic signed [B_W-1:0] b_sel;
  logic signed [P_W-1:0] mul_p;

  assign out_slot = sb_q[LAT-1];

  // Stall when the product at the output belongs to a requester that is not accepting.
  always_comb begin
    ce = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (out_slot.vld && (out_slot.tag == MUL_TAG_W'(i)) && !bus.rsp_ready[i]) begin
        ce = 1'b0;
      end
    end
  end

  // Search from ptr upward, then wrap and search from index 0.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && bus.req_valid[i] && (PTR_W'(i) >= ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && bus.req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(i);
      end
    end
  end

  // One-hot grant, suppressed while stalled or held in reset.
  always_comb begin
    gnt_oh = '0;
    if (gnt_found && ce && !reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        gnt_oh[i] = (gnt_idx == PTR_W'(i));
      end
    end
  end

  assign fire          = |gnt_oh;
  assign bus.req_ready = gnt_oh;

`ifdef FRACNET_MUL_ARB_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  logic [PTR_W-1:0] ptr_d;

  // Move the search start to just past the winner; hold when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (fire) begin
      ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Route the winner's operands into the multiplier; bubbles carry don't-care data.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == PTR_W'(i)) begin
        a_sel = bus.req_a[i*A_W +: A_W];
        b_sel = bus.req_b[i*B_W +: B_W];
      end
    end
  end

  fracnet_mul_pipe #(
    .A_W (A_W),
    .B_W (B_W),
    .P_W (P_W)
  ) u_pipe (
    .clk (clk),
    .ce  (ce),
    .a   (a_sel),
    .b   (b_sel),
    .p   (mul_p)
  );

  // Sideband shift: valid and tag march in lockstep with the multiplier stages.
  always_comb begin
    sb_d = sb_q;
    if (ce) begin
      sb_d[0].vld = fire;
      sb_d[0].tag = MUL_TAG_W'(gnt_idx);
      for (int s = 1; s < LAT; s++) begin
        sb_d[s] = sb_q[s-1];
      end
    end
  end

  // Sideband registers; reset drops everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < LAT; s++) begin
        sb_q[s] <= '0;
      end
    end else begin
      sb_q <= sb_d;
    end
  end

  // Steer the output slot back to its issuing requester.
  always_comb begin
    rsp_vld_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_vld_oh[i] = out_slot.vld && (out_slot.tag == MUL_TAG_W'(i));
    end
  end

  assign bus.rsp_valid = rsp_vld_oh;
  assign bus.rsp_p     = out_slot.vld ? mul_p : '0;

endmodule

// File: tb/tb_fracnet_mul_arbiter.sv
// Self-checking bench for fracnet_mul_arbiter against an issue-order queue model.
// Latency: model expects each product LAT cycles after grant, one more per stall cycle.
// Backpressure: exercised with directed stalls and random rsp_ready.
module tb_fracnet_mul_arbiter;
  import fracnet_mul_arb_pkg::*;

  localparam int NR = NUM_REQ_DEF;
  localparam int AW = A_W_DEF;
  localparam int BW = B_W_DEF;
  localparam int PW = P_W_DEF;

  typedef struct {
    int tag;
    int prod;
    int due;
  } ent_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fracnet_mul_arbiter_if #(.NUM_REQ(NR), .A_W(AW), .B_W(BW), .P_W(PW)) bus ();

  fracnet_mul_arbiter #(.NUM_REQ(NR), .A_W(AW), .B_W(BW), .P_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int m_ptr    = 0;
  ent_t m_q[$];
  int op_a [NR];
  int op_b [NR];

  logic [NR-1:0] obs_req_ready, obs_rsp_valid, exp_req_ready, exp_rsp_valid;
  logic [PW-1:0] obs_rsp_p, exp_rsp_p;

  task automatic drive(input logic [NR-1:0] vld, input logic [NR-1:0] rdy);
    bus.req_valid = vld;
    bus.rsp_ready = rdy;
    for (int i = 0; i < NR; i++) begin
      bus.req_a[i*AW +: AW] = op_a[i][AW-1:0];
      bus.req_b[i*BW +: BW] = op_b[i][BW-1:0];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) begin
      op_a[i] = int'($urandom_range(0, (1 << AW) - 1)) - (1 << (AW - 1));
      op_b[i] = int'($urandom_range(0, (1 << BW) - 1)) - (1 << (BW - 1));
    end
  endtask

  // One clock of the reference model: sample DUT, form expectations, then advance the queue.
  task automatic run_cycle();
    int   gnt;
    int   ht;
    logic head;
    logic ce_m;
    @(negedge clk);
    obs_req_ready = bus.req_ready;
    obs_rsp_valid = bus.rsp_valid;
    obs_rsp_p     = bus.rsp_p;
    exp_req_ready = '0;
    exp_rsp_valid = '0;
    exp_rsp_p     = '0;
    head = 1'b0;
    ht   = 0;
    if (m_q.size() > 0) begin
      if (m_q[0].due <= cyc) begin
        head = 1'b1;
        ht   = m_q[0].tag;
        exp_rsp_valid[ht] = 1'b1;
        exp_rsp_p = PW'(m_q[0].prod);
      end
    end
    ce_m = !(head && !bus.rsp_ready[ht]);
    gnt  = -1;
    if (ce_m) begin
      for (int k = 0; k < NR; k++) begin
        int i = (m_ptr + k) % NR;
        if (gnt < 0 && bus.req_valid[i]) gnt = i;
      end
    end
    if (gnt >= 0) exp_req_ready[gnt] = 1'b1;
    if (head && ce_m) void'(m_q.pop_front());
    if (!ce_m) begin
      foreach (m_q[j]) m_q[j].due++;
    end
    if (gnt >= 0) begin
      m_q.push_back('{gnt, op_a[gnt] * op_b[gnt], cyc + LAT});
`ifdef FRACNET_MUL_ARB_FIXED_PRIO_EN
      m_ptr = 0;
`else
      m_ptr = (gnt + 1) % NR;
`endif
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NR; i++) begin
      op_a[i] = 0;
      op_b[i] = 0;
    end
    reset = 1'b1;
    drive('1, '1);
    repeat (2) @(negedge clk);
    n_assert++;
    if (bus.req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_req_ready got=%b exp=0", bus.req_ready);
    end
    n_assert++;
    if (bus.rsp_valid !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid);
    end
    n_assert++;
    if (bus.rsp_p !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp_p got=%h exp=0", bus.rsp_p);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_q.delete();
    m_ptr = 0;
    drive('0, '1);
  endtask

  task automatic test_single();
    logic [PW-1:0] want;
    want = PW'(-3000);
    op_a[2] = -3;
    op_b[2] = 1000;
    for (int k = 0; k < 8; k++) begin
      drive((k == 0) ? 4'b0100 : 4'b0000, '1);
      run_cycle();
      n_assert++;
      if ({obs_req_ready, obs_rsp_valid, obs_rsp_p} !== {exp_req_ready, exp_rsp_valid, exp_rsp_p}) begin
        n_fail++;
        $display("FAIL single k=%0d got rdy=%b vld=%b p=%0d exp rdy=%b vld=%b p=%0d", k,
                 obs_req_ready, obs_rsp_valid, $signed(obs_rsp_p), exp_req_ready, exp_rsp_valid, $signed(exp_rsp_p));
      end
      if (k == 4) begin
        n_assert++;
        if (obs_rsp_valid !== 4'b0100 || obs_rsp_p !== want) begin
          n_fail++;
          $display("FAIL single_product got vld=%b p=%0d exp vld=0100 p=-3000", obs_rsp_valid, $signed(obs_rsp_p));
        end
      end
    end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 22; k++) begin
      rand_ops();
      drive((k < 16) ? 4'hF : 4'h0, '1);
      run_cycle();
      n_assert++;
      if ({obs_req_ready, obs_rsp_valid, obs_rsp_p} !== {exp_req_ready, exp_rsp_valid, exp_rsp_p}) begin
        n_fail++;
        $display("FAIL round_robin k=%0d got rdy=%b vld=%b p=%0d exp rdy=%b vld=%b p=%0d", k,
                 obs_req_ready, obs_rsp_valid, $signed(obs_rsp_p), exp_req_ready, exp_rsp_valid, $signed(exp_rsp_p));
      end
    end
  endtask

  task automatic test_extremes();
    logic [PW-1:0] want0;
    logic [PW-1:0] want1;
    want0 = PW'(16777216);
    want1 = PW'(-16744448);
    op_a[0] = -512;
    op_b[0] = -32768;
    op_a[1] = 511;
    op_b[1] = -32768;
    for (int k = 0; k < 8; k++) begin
      drive((k == 0) ? 4'b0001 : (k == 1) ? 4'b0010 : 4'b0000, '1);
      run_cycle();
      n_assert++;
      if ({obs_req_ready, obs_rsp_valid, obs_rsp_p} !== {exp_req_ready, exp_rsp_valid, exp_rsp_p}) begin
        n_fail++;
        $display("FAIL extremes k=%0d got rdy=%b vld=%b p=%0d exp rdy=%b vld=%b p=%0d", k,
                 obs_req_ready, obs_rsp_valid, $signed(obs_rsp_p), exp_req_ready, exp_rsp_valid, $signed(exp_rsp_p));
      end
      if (k == 4 || k == 5) begin
        n_assert++;
        if (obs_rsp_p !== ((k == 4) ? want0 : want1)) begin
          n_fail++;
          $display("FAIL extremes_value k=%0d got=%0d exp=%0d", k, $signed(obs_rsp_p),
                   $signed((k == 4) ? want0 : want1));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [NR-1:0] vld;
    logic [NR-1:0] rdy;
    logic [NR-1:0] want_vld;
    rand_ops();
    for (int k = 0; k < 14; k++) begin
      vld = '0;
      rdy = '1;
      if (k < 4) vld = NR'(1 << k);
      if (k >= 5 && k <= 7) begin
        vld = '1;
        rdy = 4'b1101;
      end
      drive(vld, rdy);
      run_cycle();
      n_assert++;
      if ({obs_req_ready, obs_rsp_valid, obs_rsp_p} !== {exp_req_ready, exp_rsp_valid, exp_rsp_p}) begin
        n_fail++;
        $display("FAIL backpressure k=%0d got rdy=%b vld=%b p=%0d exp rdy=%b vld=%b p=%0d", k,
                 obs_req_ready, obs_rsp_valid, $signed(obs_rsp_p), exp_req_ready, exp_rsp_valid, $signed(exp_rsp_p));
      end
      if (k >= 4 && k <= 10) begin
        want_vld = (k == 4) ? 4'b0001 : (k <= 8) ? 4'b0010 : (k == 9) ? 4'b0100 : 4'b1000;
        n_assert++;
        if (obs_rsp_valid !== want_vld || (k >= 5 && k <= 7 && obs_req_ready !== '0)) begin
          n_fail++;
          $display("FAIL backpressure_order k=%0d got vld=%b rdy=%b exp vld=%b", k, obs_rsp_valid,
                   obs_req_ready, want_vld);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    rand_ops();
    for (int k = 0; k < 3; k++) begin
      drive((k == 0) ? 4'b0010 : (k == 1) ? 4'b0100 : 4'b0000, '1);
      run_cycle();
      n_assert++;
      if ({obs_req_ready, obs_rsp_valid, obs_rsp_p} !== {exp_req_ready, exp_rsp_valid, exp_rsp_p}) begin
        n_fail++;
        $display("FAIL reset_mid_pre k=%0d got rdy=%b vld=%b exp rdy=%b vld=%b", k,
                 obs_req_ready, obs_rsp_valid, exp_req_ready, exp_rsp_valid);
      end
    end
    reset = 1'b1;
    m_q.delete();
    m_ptr = 0;
    @(negedge clk);
    n_assert++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_p} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_hold got rdy=%b vld=%b p=%0d exp all zero", bus.req_ready, bus.rsp_valid,
               $signed(bus.rsp_p));
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc++;
    for (int k = 0; k < 10; k++) begin
      drive((k == 0) ? 4'b1000 : 4'b0000, '1);
      run_cycle();
      n_assert++;
      if ({obs_req_ready, obs_rsp_valid, obs_rsp_p} !== {exp_req_ready, exp_rsp_valid, exp_rsp_p}) begin
        n_fail++;
        $display("FAIL reset_mid_post k=%0d got rdy=%b vld=%b p=%0d exp rdy=%b vld=%b p=%0d", k,
                 obs_req_ready, obs_rsp_valid, $signed(obs_rsp_p), exp_req_ready, exp_rsp_valid, $signed(exp_rsp_p));
      end
    end
  endtask

  task automatic test_bubbles();
    logic [NR-1:0] vld;
    for (int k = 0; k < 20; k++) begin
      vld = '0;
      if (k < 14 && (k % 2) == 0) begin
        rand_ops();
        vld = NR'(1 << $urandom_range(0, NR - 1));
      end
      drive(vld, '1);
      run_cycle();
      n_assert++;
      if ({obs_req_ready, obs_rsp_valid, obs_rsp_p} !== {exp_req_ready, exp_rsp_valid, exp_rsp_p}) begin
        n_fail++;
        $display("FAIL bubbles k=%0d got rdy=%b vld=%b p=%0d exp rdy=%b vld=%b p=%0d", k,
                 obs_req_ready, obs_rsp_valid, $signed(obs_rsp_p), exp_req_ready, exp_rsp_valid, $signed(exp_rsp_p));
      end
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] vld;
    logic [NR-1:0] rdy;
    for (int k = 0; k < 420; k++) begin
      rand_ops();
      vld = (k < 400) ? NR'($urandom_range(0, (1 << NR) - 1)) : '0;
      for (int i = 0; i < NR; i++) rdy[i] = (k >= 400) || ($urandom_range(0, 3) != 0);
      drive(vld, rdy);
      run_cycle();
      n_assert++;
      if ({obs_req_ready, obs_rsp_valid, obs_rsp_p} !== {exp_req_ready, exp_rsp_valid, exp_rsp_p}) begin
        n_fail++;
        $display("FAIL random k=%0d got rdy=%b vld=%b p=%0d exp rdy=%b vld=%b p=%0d", k,
                 obs_req_ready, obs_rsp_valid, $signed(obs_rsp_p), exp_req_ready, exp_rsp_valid, $signed(exp_rsp_p));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_extremes();
    test_backpressure();
    test_reset_mid();
    test_bubbles();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
